// File: rtl/fifo_async_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks (write and read side).
// Provides pointer-width derivation and Gray/binary conversion helpers.
package fifo_async_pkg;

    // Widest pointer the helpers handle; callers zero-extend into this width.
    localparam int unsigned MaxPtrW = 32;

    typedef logic [MaxPtrW-1:0] ptr_wide_t;

    // Address bits needed to index `entries` locations.
    function automatic int unsigned addr_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Pointer width: one extra wrap bit above the address bits.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

    function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
        ptr_wide_t b;
        b[MaxPtrW-1] = g[MaxPtrW-1];
        for (int i = MaxPtrW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Parameterised combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin_conv #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/wptr_and_full_async.sv
// Write-side pointer and full-flag generator for the asynchronous FIFO.
// Everything runs in the clk_w domain; rptr_gray_sync arrives already synchronised.
// Optional almost_full output is built when WPTR_ALMOST_FULL_EN is defined.
module wptr_and_full_async
    import fifo_async_pkg::*;
#(
    parameter int unsigned width     = 32,
    parameter int unsigned depth     = 1024,
    parameter int unsigned AF_THRESH = depth - 4,
    localparam int unsigned AW       = addr_width(depth),
    localparam int unsigned PW       = AW + 1
) (
    input  logic          clk_w,
    input  logic          rst_w_gen,
    input  logic          wrt_enable,
    input  logic [PW-1:0] rptr_gray_sync,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] wptr_gray,
    output logic          full,
    output logic          wrt_en,
    output logic [PW-1:0] wr_level,
    output logic          overflow
`ifdef WPTR_ALMOST_FULL_EN
    ,
    output logic          almost_full
`endif
);

    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  wptr_gray_q, wptr_gray_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  wptr_inc;
    logic [PW-1:0]  rbin;
    ptr_wide_t      gray_wide;

    // Read pointer back to binary for the full and level arithmetic.
    gray2bin_conv #(
        .N (PW)
    ) u_rptr_conv (
        .gray (rptr_gray_sync),
        .bin  (rbin)
    );

    assign wptr_inc  = wptr_q + PW'(1);
    assign gray_wide = bin2gray(ptr_wide_t'(wptr_inc));

    // Full when the wrap bits differ but the address bits match.
    always_comb begin
        full   = (wptr_q[AW] != rbin[AW]) && (wptr_q[AW-1:0] == rbin[AW-1:0]);
        wrt_en = wrt_enable & ~full;
    end

    // Occupancy as seen from the write side; modulo pointer width handles the wrap.
    always_comb begin
        wr_level = wptr_q - rbin;
    end

    // Next-state for pointers and sticky overflow.
    always_comb begin
        wptr_d      = wptr_q;
        wptr_gray_d = wptr_gray_q;
        overflow_d  = overflow_q;
        if (wrt_en) begin
            wptr_d      = wptr_inc;
            wptr_gray_d = gray_wide[PW-1:0];
        end
        if (wrt_enable && full) begin
            overflow_d = 1'b1;
        end
    end

    // State registers; reset wins over any write request in the same cycle.
    always_ff @(posedge clk_w) begin
        if (rst_w_gen) begin
            wptr_q      <= '0;
            wptr_gray_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            wptr_gray_q <= wptr_gray_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wptr      = wptr_q;
    assign wptr_gray = wptr_gray_q;
    assign overflow  = overflow_q;

`ifdef WPTR_ALMOST_FULL_EN
    assign almost_full = ({{(MaxPtrW - PW){1'b0}}, wr_level} >= AF_THRESH);
`endif

    // Upper Gray bits are always zero; width is carried only for interface symmetry.
    logic          unused_gray_hi;
    logic [31:0]   unused_cfg;
    assign unused_gray_hi = ^gray_wide[MaxPtrW-1:PW];
    assign unused_cfg     = width ^ AF_THRESH;

endmodule

// File: tb/tb_wptr_and_full_async.sv
// Directed bench for wptr_and_full_async at depth 8 (4-bit pointers).
module tb_wptr_and_full_async;
    import fifo_async_pkg::*;

    logic       clk_w = 1'b0;
    logic       rst_w_gen = 1'b1;
    logic       wrt_enable = 1'b0;
    logic [3:0] rptr_gray_sync = 4'd0;
    logic [3:0] wptr, wptr_gray, wr_level;
    logic       full, wrt_en, overflow;
`ifdef WPTR_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    wptr_and_full_async #(
        .width     (32),
        .depth     (8),
        .AF_THRESH (6)
    ) dut (
        .clk_w          (clk_w),
        .rst_w_gen      (rst_w_gen),
        .wrt_enable     (wrt_enable),
        .rptr_gray_sync (rptr_gray_sync),
        .wptr           (wptr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .wrt_en         (wrt_en),
        .wr_level       (wr_level),
        .overflow       (overflow)
`ifdef WPTR_ALMOST_FULL_EN
        ,
        .almost_full    (almost_full)
`endif
    );

    always #5 clk_w = ~clk_w;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Illegal-input guard: the reader must never appear more than depth behind.
    always @(negedge clk_w) begin
        logic [3:0] lvl;
        lvl = wptr - 4'(gray2bin(ptr_wide_t'(rptr_gray_sync)));
        if (!rst_w_gen) begin
            assert (lvl <= 4'd8) else $error("illegal rptr_gray_sync, level %0d", lvl);
        end
    end

    typedef struct {
        logic       rst;
        logic       we;
        logic [3:0] rg;
        logic [3:0] e_wptr;
        logic [3:0] e_gray;
        logic       e_full;
        logic       e_wen;
        logic [3:0] e_lvl;
        logic       e_ov;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic w, logic [3:0] g, logic [3:0] p,
                                logic [3:0] pg, logic f, logic en, logic [3:0] l, logic o);
        vec_t v;
        v.rst = r; v.we = w; v.rg = g; v.e_wptr = p; v.e_gray = pg;
        v.e_full = f; v.e_wen = en; v.e_lvl = l; v.e_ov = o;
        return v;
    endfunction

    function automatic logic [3:0] g4(logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic edge_n(int n);
        for (int k = 0; k < n; k++) @(posedge clk_w);
        #1;
    endtask

    initial begin
        // Each record: inputs held across one rising edge, outputs checked 1 time unit after.
        //                rst we  rg     wptr   gray   full wen lvl   ov
        vecs[0]  = mk(1, 1, 4'd0,  4'd0,  4'd0,  0, 1, 4'd0, 0);
        vecs[1]  = mk(1, 1, 4'd0,  4'd0,  4'd0,  0, 1, 4'd0, 0);
        vecs[2]  = mk(0, 1, 4'd0,  4'd1,  4'd1,  0, 1, 4'd1, 0);
        vecs[3]  = mk(0, 1, 4'd0,  4'd2,  4'd3,  0, 1, 4'd2, 0);
        vecs[4]  = mk(0, 1, 4'd0,  4'd3,  4'd2,  0, 1, 4'd3, 0);
        vecs[5]  = mk(0, 1, 4'd0,  4'd4,  4'd6,  0, 1, 4'd4, 0);
        vecs[6]  = mk(0, 1, 4'd0,  4'd5,  4'd7,  0, 1, 4'd5, 0);
        vecs[7]  = mk(0, 1, 4'd0,  4'd6,  4'd5,  0, 1, 4'd6, 0);
        vecs[8]  = mk(0, 1, 4'd0,  4'd7,  4'd4,  0, 1, 4'd7, 0);
        vecs[9]  = mk(0, 1, 4'd0,  4'd8,  4'd12, 1, 0, 4'd8, 0);
        vecs[10] = mk(0, 1, 4'd0,  4'd8,  4'd12, 1, 0, 4'd8, 1);
        vecs[11] = mk(0, 1, 4'd12, 4'd9,  4'd13, 0, 1, 4'd1, 1);
        vecs[12] = mk(0, 1, 4'd12, 4'd10, 4'd15, 0, 1, 4'd2, 1);
        vecs[13] = mk(0, 1, 4'd12, 4'd11, 4'd14, 0, 1, 4'd3, 1);
        vecs[14] = mk(0, 1, 4'd12, 4'd12, 4'd10, 0, 1, 4'd4, 1);
        vecs[15] = mk(0, 1, 4'd12, 4'd13, 4'd11, 0, 1, 4'd5, 1);
        vecs[16] = mk(0, 1, 4'd12, 4'd14, 4'd9,  0, 1, 4'd6, 1);
        vecs[17] = mk(0, 1, 4'd12, 4'd15, 4'd8,  0, 1, 4'd7, 1);
        vecs[18] = mk(0, 1, 4'd12, 4'd0,  4'd0,  1, 0, 4'd8, 1);
        vecs[19] = mk(1, 0, 4'd0,  4'd0,  4'd0,  0, 0, 4'd0, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_w);
            rst_w_gen      = vecs[i].rst;
            wrt_enable     = vecs[i].we;
            rptr_gray_sync = vecs[i].rg;
            edge_n(1);
            chk($sformatf("v%0d wptr", i),      wptr,      vecs[i].e_wptr);
            chk($sformatf("v%0d wptr_gray", i), wptr_gray, vecs[i].e_gray);
            chk($sformatf("v%0d full", i),      full,      vecs[i].e_full);
            chk($sformatf("v%0d wrt_en", i),    wrt_en,    vecs[i].e_wen);
            chk($sformatf("v%0d wr_level", i),  wr_level,  vecs[i].e_lvl);
            chk($sformatf("v%0d overflow", i),  overflow,  vecs[i].e_ov);
        end

        // Reset while full and requesting: write discarded, overflow not set.
        @(negedge clk_w);
        rst_w_gen = 1'b0; wrt_enable = 1'b1; rptr_gray_sync = 4'd0;
        edge_n(8);
        @(negedge clk_w);
        chk("rst_mid pre full", full, 1'b1);
        rst_w_gen = 1'b1;
        edge_n(1);
        chk("rst_mid wptr", wptr, 4'd0);
        chk("rst_mid gray", wptr_gray, 4'd0);
        chk("rst_mid overflow", overflow, 1'b0);

        // Reader advances while full and requesting: write taken on that edge.
        @(negedge clk_w);
        rst_w_gen = 1'b0; wrt_enable = 1'b1;
        edge_n(8);
        @(negedge clk_w);
        #1;
        chk("unblock pre full", full, 1'b1);
        chk("unblock pre wrt_en", wrt_en, 1'b0);
        rptr_gray_sync = 4'b0001;
        #1;
        chk("unblock full drop", full, 1'b0);
        chk("unblock wrt_en", wrt_en, 1'b1);
        chk("unblock level", wr_level, 4'd7);
        edge_n(1);
        chk("unblock wptr", wptr, 4'b1001);
        chk("unblock gray", wptr_gray, 4'b1101);
        chk("unblock overflow", overflow, 1'b0);
        chk("unblock refull", full, 1'b1);

        // Gray integrity over a full pointer cycle with the reader tracking.
        @(negedge clk_w);
        rst_w_gen = 1'b1; wrt_enable = 1'b0; rptr_gray_sync = 4'd0;
        edge_n(1);
        begin
            logic [3:0] prev_g;
            logic [3:0] cnt;
            prev_g = 4'd0;
            cnt = 4'd0;
            @(negedge clk_w);
            rst_w_gen = 1'b0;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk_w);
                wrt_enable = 1'b1;
                rptr_gray_sync = g4(cnt);
                edge_n(1);
                cnt = cnt + 4'd1;
                chk($sformatf("gray seq %0d value", i), wptr_gray, g4(cnt));
                chk($sformatf("gray seq %0d onebit", i), $countones(prev_g ^ wptr_gray), 1);
                prev_g = wptr_gray;
            end
            chk("gray seq level", wr_level, 4'd1);
        end

`ifdef WPTR_ALMOST_FULL_EN
        @(negedge clk_w);
        rst_w_gen = 1'b1; wrt_enable = 1'b0; rptr_gray_sync = 4'd0;
        edge_n(1);
        @(negedge clk_w);
        rst_w_gen = 1'b0; wrt_enable = 1'b1;
        edge_n(5);
        @(negedge clk_w);
        wrt_enable = 1'b0;
        chk("af level5", wr_level, 4'd5);
        chk("af at 5", almost_full, 1'b0);
        wrt_enable = 1'b1;
        edge_n(1);
        @(negedge clk_w);
        wrt_enable = 1'b0;
        chk("af level6", wr_level, 4'd6);
        chk("af at 6", almost_full, 1'b1);
        rst_w_gen = 1'b1;
        edge_n(1);
        chk("af after reset", almost_full, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wptr_and_full_async.md
Name: wptr_and_full_async

Overview:
- Write-side pointer and full-flag generator for the asynchronous FIFO.
- Sits upstream of the read-pointer/empty block, which receives its pointer through the write-to-read synchroniser.
- Accepts the synchronised Gray read pointer and converts it to binary. Produces:
  - the write pointer, binary and registered Gray;
  - full, the qualified write enable, fill level and a sticky overflow flag.
- All logic is in the write clock domain.

Parameters:
- width, 32, FIFO data width; carried for interface consistency, not used by pointer logic.
- depth, 1024, FIFO entries; power of two, >= 2. AW = $clog2(depth); pointers are AW+1 bits.
- AF_THRESH, depth-4, almost-full threshold in entries; used only with WPTR_ALMOST_FULL_EN.

Ports:
- clk_w  input  1  write-domain clock.
- rst_w_gen  input  1  reset; synchronous, active-high.
- wrt_enable  input  1  write request from producer.
- rptr_gray_sync  input  AW+1  read pointer (Gray), already synchronised into clk_w.
- wptr  output  AW+1  binary write pointer; MSB is the wrap bit.
- wptr_gray  output  AW+1  registered Gray write pointer; sent to the synchroniser.
- full  output  1  FIFO full.
- wrt_en  output  1  qualified write strobe: wrt_enable & ~full.
- wr_level  output  AW+1  entries occupied as seen from the write side, 0..depth.
- overflow  output  1  sticky; set on a write attempt while full.
- almost_full  output  1  present only with WPTR_ALMOST_FULL_EN.

Behaviour:
- One clock (clk_w). Reset rst_w_gen is synchronous and active-high, sampled at the rising edge, and overrides all other inputs.
- Reset values:
  - wptr = 0, wptr_gray = 0, overflow = 0.
  - full, wr_level and almost_full are combinational. With rptr_gray_sync = 0 they give full = 0, wr_level = 0, almost_full = 0.
- rbin = Gray-to-binary(rptr_gray_sync), combinational:
  - rbin[AW] = g[AW];
  - rbin[i] = rbin[i+1] ^ g[i].
- full = (wptr[AW] != rbin[AW]) && (wptr[AW-1:0] == rbin[AW-1:0]). Combinational from registered wptr and the input; no extra latency.
- wrt_en = wrt_enable & ~full. The memory write and the pointer advance happen on the same edge.
- On a clock edge with wrt_en = 1:
  - wptr <= wptr + 1, modulo 2^(AW+1), wrapping naturally;
  - wptr_gray <= (wptr+1) ^ ((wptr+1) >> 1).
  - Both registers update on the same edge. wptr_gray never depends combinationally on inputs.
- Otherwise wptr and wptr_gray hold.
- wr_level = (wptr - rbin) mod 2^(AW+1), combinational.
- overflow:
  - set to 1 on an edge where wrt_enable = 1 and full = 1;
  - cleared only by reset.
  - When the write is blocked, wptr/wptr_gray do not move.
- Read side advancing while full: if rptr_gray_sync changes so that full drops, wrt_en rises in the same cycle and the write is taken on that edge.
- Reset mid-operation: the pointers return to 0 on the next edge regardless of wrt_enable. Any write requested in that cycle is discarded and does not set overflow.
- Consecutive wptr_gray values must differ in exactly one bit, including the wrap from 2^(AW+1)-1 to 0.
- An rptr_gray_sync implying wr_level > depth is illegal input. It is not corrected in RTL; the bench asserts against it.

Optional Feature:
- Macro: WPTR_ALMOST_FULL_EN.
- Defined:
  - almost_full port exists;
  - almost_full = (wr_level >= AF_THRESH), combinational, 0 under reset conditions.
- Undefined: almost_full port and its logic are absent. AF_THRESH is unused.

Decomposition:
- Shared package fifo_async_pkg:
  - pointer-width constant derivation (AW from depth);
  - functions bin2gray and gray2bin.
  - The read-side block reuses the same package.
- One sub-module is natural: gray2bin_conv, a parameterised combinational Gray-to-binary converter instantiated on rptr_gray_sync.

Test Plan (depth = 8, AW = 3, 4-bit pointers):
1. Reset: hold rst_w_gen = 1 with wrt_enable = 1 for 2 cycles -> wptr = 0000, wptr_gray = 0000, full = 0, wr_level = 0, overflow = 0.
2. Fill to full: rptr_gray_sync = 0000, 8 writes -> wptr = 1000, wptr_gray = 1100, full = 1, wr_level = 8. 9th write request -> wrt_en = 0, wptr stays 1000, overflow = 1.
3. Wrap: after step 2 drive rptr_gray_sync = 1100 (bin 8), write 8 more -> wptr wraps to 0000, wptr_gray = 0000, full = 1, wr_level = 8.
4. Gray integrity: 16 consecutive writes with the reader tracking -> every successive wptr_gray differs in exactly one bit, including 1000 -> 0000 (bin 15 -> 0).
5. Unblock while requesting: full with wrt_enable = 1, rptr_gray_sync changes 0000 -> 0001 -> full = 0 and wrt_en = 1 the same cycle; the next edge gives wptr 1000 -> 1001 and overflow stays at its prior value.
6. With WPTR_ALMOST_FULL_EN, AF_THRESH = 6: wr_level = 5 -> almost_full = 0; after one more write, wr_level = 6 -> almost_full = 1. Assert rst_w_gen -> almost_full = 0 after the edge.
